lr_sequencer: RTL and testbench
===============================

LR_SEQUENCER -- requirements
Module: lr_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving sample-address and sample-count width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-005 The block SHALL have port n_samples, input, ADDR_W bits: sample count, latched into n_reg when start is accepted.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous cancel of the current run.
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port len_err, output, 1 bit: set when a run is rejected for a zero sample count.
REQ-010 The block SHALL have port addr, output, ADDR_W bits: sample memory read address.
REQ-011 The block SHALL have port rd_en, output, 1 bit: memory read strobe; data is valid one cycle later.
REQ-012 The block SHALL have ports clr_acc, ld_acc, ld_mean and ld_coef, each output, 1 bit: datapath clear and load strobes.
REQ-013 The block SHALL have port err_valid, output, 1 bit, and port err_ready, input, 1 bit: residual output handshake.
REQ-014 The block SHALL have port err_idx, output, ADDR_W bits: index of the residual currently offered.

Function
REQ-015 The block SHALL implement states IDLE, INIT, ACCUM, DRAIN, MEAN, COEF, ERR_RD, ERR_OUT and FIN.
REQ-016 In IDLE with start=1 and n_samples!=0, the block SHALL latch n_reg, clear len_err and go to INIT.
REQ-017 In IDLE with start=1 and n_samples=0, the block SHALL set len_err, pulse done in the next cycle and stay in IDLE.
REQ-018 In IDLE with start=0, the block SHALL hold its state.
REQ-019 In INIT (one cycle), the block SHALL assert clr_acc, set addr=0 and go to ACCUM.
REQ-020 In ACCUM, the block SHALL assert rd_en every cycle with addr = 0, 1, ... n_reg-1.
REQ-021 The block SHALL go from ACCUM to DRAIN in the cycle addr=n_reg-1 is issued.
REQ-022 ld_acc SHALL be rd_en of ACCUM delayed by one register stage, giving exactly n_reg ld_acc pulses.
REQ-023 The last ld_acc pulse SHALL occur in DRAIN; DRAIN lasts one cycle and then goes to MEAN.
REQ-024 MEAN (one cycle, ld_mean=1) SHALL go to COEF; COEF (one cycle, ld_coef=1) SHALL reset addr to 0 and go to ERR_RD.
REQ-025 In ERR_RD (one cycle), the block SHALL assert rd_en at addr and then go to ERR_OUT.
REQ-026 In ERR_OUT, the block SHALL hold err_valid=1 and err_idx=addr stable until err_ready=1.
REQ-027 On an ERR_OUT handshake with addr=n_reg-1, the block SHALL go to FIN; otherwise it SHALL increment addr and go to ERR_RD.
REQ-028 Each residual SHALL take at least 2 cycles; err_ready while err_valid=0 SHALL be ignored.
REQ-029 FIN SHALL pulse done for one cycle and then return to IDLE.
REQ-030 Address arithmetic SHALL be unsigned modulo 2^ADDR_W; n_samples = 2^ADDR_W-1 SHALL be supported without wrap-around.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with all strobes low and no done pulse.
REQ-032 abort SHALL take priority over a simultaneous err_ready handshake.
REQ-033 start while busy=1 SHALL be ignored, and n_reg SHALL not change mid-run.
REQ-034 clr_acc, ld_mean, ld_coef, rd_en, err_valid and busy SHALL be decoded from state; done and ld_acc SHALL be registered.

Reset
REQ-035 rst=1 SHALL asynchronously force state IDLE, addr=0, n_reg=0, len_err=0 and the ld_acc pipeline register to 0.
REQ-036 During reset, all outputs SHALL be 0.
REQ-037 Reset asserted mid-run SHALL discard the run without a done pulse.
REQ-038 After reset release, the first start SHALL be honoured on the first rising edge.

Verification
REQ-039 Scenario: n_samples=4, start, err_ready=1 -> 1 clr_acc; rd_en with addr 0-3; ld_acc 4 pulses one cycle later; 1 ld_mean; 1 ld_coef; err_idx 0-3; single done; total 17 cycles from start to done.
REQ-040 Scenario: n_samples=3, err_ready held low for 5 cycles on idx 1 -> err_valid and err_idx=1 held for all 5 cycles; no addr change; done after idx 2 handshake.
REQ-041 Scenario: n_samples=0, start -> len_err=1; done pulse; no rd_en or clr_acc; busy stays 0.
REQ-042 Scenario: abort during ACCUM at addr=2 -> IDLE next cycle; no ld_mean; no done; a new start with n=2 then runs cleanly.
REQ-043 Scenario: rst asserted in ERR_OUT asynchronously between edges -> outputs 0 immediately; start after release produces a fresh full run.
REQ-044 Scenario: start pulsed again during COEF, and n_samples=255 with ADDR_W=8 -> second start ignored; 255 ld_acc pulses; last err_idx=254; no wrap.

Source files
------------

// File: rtl/lr_sequencer_if.sv
// lr_sequencer_if
// Groups the run-control, sample-memory, datapath-strobe and residual
// handshake signals of the LR sequencer.
//   master : the controller side that issues runs and consumes residuals
//   slave  : the sequencer itself
// Signals: start/n_samples/abort (run control), busy/done/len_err (status),
// addr/rd_en (sample memory), clr_acc/ld_acc/ld_mean/ld_coef (datapath),
// err_valid/err_ready/err_idx (residual handshake).
interface lr_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] n_samples;
    logic              abort;
    logic              busy;
    logic              done;
    logic              len_err;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              clr_acc;
    logic              ld_acc;
    logic              ld_mean;
    logic              ld_coef;
    logic              err_valid;
    logic              err_ready;
    logic [ADDR_W-1:0] err_idx;

    modport master (
        output start, n_samples, abort, err_ready,
        input  busy, done, len_err, addr, rd_en, clr_acc, ld_acc,
               ld_mean, ld_coef, err_valid, err_idx
    );

    modport slave (
        input  start, n_samples, abort, err_ready,
        output busy, done, len_err, addr, rd_en, clr_acc, ld_acc,
               ld_mean, ld_coef, err_valid, err_idx
    );
endinterface

// File: rtl/lr_sequencer.sv
// lr_sequencer
// Control sequencer for a linear-regression style datapath: clears the
// accumulators, streams n samples into them, computes mean and coefficient,
// then re-reads every sample and offers one residual per sample over a
// valid/ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : lr_sequencer_if.slave (run control, status, memory, strobes,
//          residual handshake)
module lr_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    lr_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_ACCUM  = 4'd2,
        S_DRAIN  = 4'd3,
        S_MEAN   = 4'd4,
        S_COEF   = 4'd5,
        S_ERR_RD = 4'd6,
        S_ERR_OUT= 4'd7,
        S_FIN    = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_fsm_next;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_n_reg;
    logic              r_len_err;
    logic              r_done;
    logic              r_ld_acc;

    logic w_idle;
    logic w_accept;
    logic w_zero_req;
    logic w_last;
    logic w_hs;
    logic w_abort;
    logic w_clr_acc;
    logic w_rd_en;
    logic w_ld_mean;
    logic w_ld_coef;
    logic w_err_valid;

    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = w_idle && bus.start && (bus.n_samples != {ADDR_W{1'b0}});
    assign w_zero_req = w_idle && bus.start && (bus.n_samples == {ADDR_W{1'b0}});
    // n_reg is never zero inside a run, so n_reg-1 cannot wrap here
    assign w_last     = (r_addr == (r_n_reg - {{(ADDR_W-1){1'b0}}, 1'b1}));
    assign w_hs       = (r_state == S_ERR_OUT) && bus.err_ready;
    assign w_abort    = bus.abort && !w_idle;

    // Next-state and state-decoded strobe logic
    always_comb begin
        w_fsm_next  = r_state;
        w_clr_acc   = 1'b0;
        w_rd_en     = 1'b0;
        w_ld_mean   = 1'b0;
        w_ld_coef   = 1'b0;
        w_err_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_fsm_next = S_INIT;
                end else begin
                    w_fsm_next = S_IDLE;
                end
            end
            S_INIT: begin
                w_clr_acc  = 1'b1;
                w_fsm_next = S_ACCUM;
            end
            S_ACCUM: begin
                w_rd_en = 1'b1;
                if (w_last) begin
                    w_fsm_next = S_DRAIN;
                end else begin
                    w_fsm_next = S_ACCUM;
                end
            end
            S_DRAIN: begin
                w_fsm_next = S_MEAN;
            end
            S_MEAN: begin
                w_ld_mean  = 1'b1;
                w_fsm_next = S_COEF;
            end
            S_COEF: begin
                w_ld_coef  = 1'b1;
                w_fsm_next = S_ERR_RD;
            end
            S_ERR_RD: begin
                w_rd_en    = 1'b1;
                w_fsm_next = S_ERR_OUT;
            end
            S_ERR_OUT: begin
                w_err_valid = 1'b1;
                if (bus.err_ready) begin
                    w_fsm_next = w_last ? S_FIN : S_ERR_RD;
                end else begin
                    w_fsm_next = S_ERR_OUT;
                end
            end
            S_FIN: begin
                w_fsm_next = S_IDLE;
            end
            default: begin
                w_fsm_next = S_IDLE;
            end
        endcase
        // abort outranks every other transition, including a residual handshake
        w_next = w_abort ? S_IDLE : w_fsm_next;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Run registers: sample count, address counter, error flag, done/ld_acc stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= {ADDR_W{1'b0}};
            r_n_reg   <= {ADDR_W{1'b0}};
            r_len_err <= 1'b0;
            r_done    <= 1'b0;
            r_ld_acc  <= 1'b0;
        end else begin
            // ld_acc trails the ACCUM read by one cycle; an abort kills the pending load
            r_ld_acc <= (r_state == S_ACCUM) && !bus.abort;
            r_done   <= w_zero_req || (w_hs && w_last && !bus.abort);
            if (w_accept) begin
                r_len_err <= 1'b0;
                r_n_reg   <= bus.n_samples;
            end else if (w_zero_req) begin
                r_len_err <= 1'b1;
            end
            if (w_abort) begin
                r_addr <= {ADDR_W{1'b0}};
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_addr <= {ADDR_W{1'b0}};
                        end
                    end
                    S_ACCUM: begin
                        if (!w_last) begin
                            r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                    S_COEF: begin
                        r_addr <= {ADDR_W{1'b0}};
                    end
                    S_ERR_OUT: begin
                        if (bus.err_ready && !w_last) begin
                            r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        r_addr <= r_addr;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = !w_idle;
    assign bus.done      = r_done;
    assign bus.len_err   = r_len_err;
    assign bus.addr      = r_addr;
    assign bus.rd_en     = w_rd_en;
    assign bus.clr_acc   = w_clr_acc;
    assign bus.ld_acc    = r_ld_acc;
    assign bus.ld_mean   = w_ld_mean;
    assign bus.ld_coef   = w_ld_coef;
    assign bus.err_valid = w_err_valid;
    assign bus.err_idx   = r_addr;

endmodule

// File: tb/tb_lr_sequencer.sv
// tb_lr_sequencer
// Scoreboard bench for lr_sequencer: each scenario pushes its expected
// strobe/handshake events into a queue before driving stimulus; a monitor
// on the falling edge pops and compares every event the DUT produces.
module tb_lr_sequencer;

    localparam int AW = 8;

    localparam int T_CLR  = 1;
    localparam int T_RD   = 2;
    localparam int T_LDA  = 3;
    localparam int T_MEAN = 4;
    localparam int T_COEF = 5;
    localparam int T_ERR  = 6;
    localparam int T_DONE = 7;

    logic clk;
    logic rst;

    lr_sequencer_if #(.ADDR_W(AW)) bus ();

    lr_sequencer #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int tag, input int val);
        exp_q.push_back((tag << 16) | val);
    endtask

    task automatic sb_check(input int tag, input int val);
        int act;
        int exp;
        act = (tag << 16) | val;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_extra: got event %0h, expected none", act);
        end else begin
            exp = exp_q.pop_front();
            chk("sb_event", act, exp);
        end
    endtask

    // Monitor: every strobe or handshake the DUT shows is matched against the queue
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.clr_acc)                   sb_check(T_CLR, 0);
            if (bus.rd_en)                     sb_check(T_RD, int'(bus.addr));
            if (bus.ld_acc)                    sb_check(T_LDA, 0);
            if (bus.ld_mean)                   sb_check(T_MEAN, 0);
            if (bus.ld_coef)                   sb_check(T_COEF, 0);
            if (bus.err_valid && bus.err_ready) sb_check(T_ERR, int'(bus.err_idx));
            if (bus.done)                      sb_check(T_DONE, int'(bus.len_err));
        end
    end

    task automatic push_run(input int n);
        if (n == 0) begin
            push(T_DONE, 1);
        end else begin
            push(T_CLR, 0);
            for (int k = 0; k < n; k++) begin
                push(T_RD, k);
                if (k > 0) push(T_LDA, 0);
            end
            push(T_LDA, 0);
            push(T_MEAN, 0);
            push(T_COEF, 0);
            for (int i = 0; i < n; i++) begin
                push(T_RD, i);
                push(T_ERR, i);
            end
            push(T_DONE, 0);
        end
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.n_samples = AW'(n);
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.n_samples = AW'(n) ^ 8'h5A;
    endtask

    // Full run: optional stall on one residual, optional start retry during COEF
    task automatic run(input int n, input int stall_idx, input int stall_n,
                       input int exp_lat, input bit coef_restart);
        int lat;
        int stalling;
        bit stalled;
        push_run(n);
        bus.err_ready = 1'b1;
        pulse_start(n);
        lat = 1;
        stalling = 0;
        stalled = 1'b0;
        if (n == 0) chk("zero_busy", {31'd0, bus.busy}, 32'd0);
        while (!bus.done && lat < 3000) begin
            if (!stalled && bus.err_valid && int'(bus.err_idx) == stall_idx) begin
                stalled  = 1'b1;
                stalling = stall_n;
            end
            if (stalling > 0) begin
                bus.err_ready = 1'b0;
                chk("stall_valid", {31'd0, bus.err_valid}, 32'd1);
                chk("stall_idx", 32'(bus.err_idx), 32'(stall_idx));
                stalling--;
            end else begin
                bus.err_ready = 1'b1;
            end
            if (coef_restart && bus.ld_coef) begin
                bus.start     = 1'b1;
                bus.n_samples = 8'd5;
            end else begin
                bus.start     = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        chk("done_seen", {31'd0, bus.done}, 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        chk("done_1cyc", {31'd0, bus.done}, 32'd0);
        chk("idle_after", {31'd0, bus.busy}, 32'd0);
    endtask

    function automatic logic [31:0] all_outs();
        return {bus.busy, bus.done, bus.len_err, bus.rd_en, bus.clr_acc, bus.ld_acc,
                bus.ld_mean, bus.ld_coef, bus.err_valid, bus.addr, bus.err_idx};
    endfunction

    initial begin
        int k;
        clk = 1'b0;
        rst = 1'b1;
        bus.start     = 1'b0;
        bus.n_samples = 8'd0;
        bus.abort     = 1'b0;
        bus.err_ready = 1'b1;
        #12;
        chk("reset_outs", all_outs(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic 4-sample run
        run(4, -1, 0, 17, 1'b0);
        // Residual 1 stalled for 5 cycles
        run(3, 1, 5, 19, 1'b0);
        // Zero-length request
        run(0, -1, 0, 1, 1'b0);

        // Abort in ACCUM at addr 2
        push(T_CLR, 0);
        push(T_RD, 0);
        push(T_RD, 1);
        push(T_LDA, 0);
        push(T_RD, 2);
        push(T_LDA, 0);
        pulse_start(8);
        k = 0;
        while (!(bus.rd_en && bus.addr == 8'd2) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_reach", 32'(k), 32'd3);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_strobes", {29'd0, bus.ld_acc, bus.ld_mean, bus.done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_flush", 32'(exp_q.size()), 32'd0);
        run(2, -1, 0, 11, 1'b0);

        // Asynchronous reset while a residual is waiting
        push(T_CLR, 0);
        push(T_RD, 0);
        push(T_RD, 1);
        push(T_LDA, 0);
        push(T_RD, 2);
        push(T_LDA, 0);
        push(T_LDA, 0);
        push(T_MEAN, 0);
        push(T_COEF, 0);
        push(T_RD, 0);
        bus.err_ready = 1'b0;
        pulse_start(3);
        k = 0;
        while (!bus.err_valid && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk("err_out_reach", {31'd0, bus.err_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", all_outs(), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_flush", 32'(exp_q.size()), 32'd0);
        run(4, -1, 0, 17, 1'b0);

        // Full-range count with a start retry during COEF
        run(255, -1, 0, 770, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
